// File: rtl/round_controller_if.sv
// Round controller bus: game inputs from the environment and the
// timer, word-ROM and status outputs back from the controller.
interface round_controller_if;
  logic       start_i;
  logic       abort_i;
  logic       answer_valid_i;
  logic       answer_correct_i;
  logic       timeout_i;
  logic       timer_enable_o;
  logic       timer_reconfig_o;
  logic       word_next_o;
  logic [3:0] score_o;
  logic [1:0] lives_o;
  logic [3:0] round_o;
  logic       game_over_o;
  logic       win_o;
  logic [2:0] state_o;

  // environment side: drives game events, observes controller outputs
  modport master (
    output start_i, abort_i, answer_valid_i, answer_correct_i, timeout_i,
    input  timer_enable_o, timer_reconfig_o, word_next_o, score_o, lives_o,
           round_o, game_over_o, win_o, state_o
  );

  // controller side
  modport slave (
    input  start_i, abort_i, answer_valid_i, answer_correct_i, timeout_i,
    output timer_enable_o, timer_reconfig_o, word_next_o, score_o, lives_o,
           round_o, game_over_o, win_o, state_o
  );
endinterface

// File: rtl/round_controller.sv
// Word-game round sequencer: loads a word, runs the countdown timer,
// scores the answer or timeout, and ends the game on lives or rounds.
//
// state | meaning
// IDLE  | waiting for start, timer stopped
// LOAD  | one cycle: reload timer, advance word address
// PLAY  | timer running, waiting for answer or timeout
// NEXT  | one cycle: count the round, decide DONE or LOAD
// DONE  | game over, results held until the next start
module round_controller #(
  parameter int unsigned MAX_ROUNDS = 10,
  parameter int unsigned LIVES      = 3
) (
  input logic              clk,
  input logic              rst,
  round_controller_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_NEXT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [3:0] ROUND_LAST = 4'(MAX_ROUNDS);

  logic [2:0] state_q, state_d;
  logic [3:0] score_q, score_d;
  logic [1:0] lives_q, lives_d;
  logic [3:0] round_q, round_d;
  logic       win_q, win_d;
  logic       timer_enable_q, timer_reconfig_q, word_next_q, game_over_q;

  logic [3:0] score_inc;
  logic [1:0] lives_dec;
  logic [3:0] round_inc;

  // saturating score, non-underflowing lives
  assign score_inc = (score_q == 4'd15) ? score_q : score_q + 4'd1;
  assign lives_dec = (lives_q == 2'd0) ? lives_q : lives_q - 2'd1;
  assign round_inc = round_q + 4'd1;

  // next-state and counter updates; abort beats every other event
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    round_d = round_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_LOAD;
          score_d = 4'd0;
          round_d = 4'd0;
          lives_d = LIVES_INIT;
        end
      end
      S_LOAD: begin
        state_d = bus.abort_i ? S_IDLE : S_PLAY;
      end
      S_PLAY: begin
        if (bus.abort_i) begin
          state_d = S_IDLE;
        end else if (bus.answer_valid_i) begin
          if (bus.answer_correct_i) score_d = score_inc;
          else                      lives_d = lives_dec;
          state_d = S_NEXT;
        end else if (bus.timeout_i) begin
          lives_d = lives_dec;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (bus.abort_i) begin
          state_d = S_IDLE;
        end else begin
          round_d = round_inc;
          if (lives_q == 2'd0) begin
            state_d = S_DONE;
            win_d   = 1'b0;
          end else if (round_inc == ROUND_LAST) begin
            state_d = S_DONE;
            win_d   = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        if (bus.start_i) begin
          state_d = S_LOAD;
          score_d = 4'd0;
          round_d = 4'd0;
          lives_d = LIVES_INIT;
          win_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        win_d   = 1'b0;
      end
    endcase
  end

  // state, counters and registered outputs; outputs decode the next state
  // so they line up with the state register after the edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      score_q          <= 4'd0;
      lives_q          <= LIVES_INIT;
      round_q          <= 4'd0;
      win_q            <= 1'b0;
      timer_enable_q   <= 1'b0;
      timer_reconfig_q <= 1'b0;
      word_next_q      <= 1'b0;
      game_over_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      score_q          <= score_d;
      lives_q          <= lives_d;
      round_q          <= round_d;
      win_q            <= win_d;
      timer_enable_q   <= (state_d == S_PLAY);
      timer_reconfig_q <= (state_d == S_LOAD);
      word_next_q      <= (state_d == S_LOAD);
      game_over_q      <= (state_d == S_DONE);
    end
  end

  assign bus.state_o          = state_q;
  assign bus.score_o          = score_q;
  assign bus.lives_o          = lives_q;
  assign bus.round_o          = round_q;
  assign bus.win_o            = win_q;
  assign bus.timer_enable_o   = timer_enable_q;
  assign bus.timer_reconfig_o = timer_reconfig_q;
  assign bus.word_next_o      = word_next_q;
  assign bus.game_over_o      = game_over_q;

endmodule
